// File: rtl/ecc_pkg.sv
// Shared SECDED helpers: code geometry, position classification, decode status.
package ecc_pkg;

    typedef enum logic [1:0] {
        EccOk,
        EccSingle,
        EccDouble
    } ecc_status_e;

    // Smallest P with 2^P >= data_width + P + 1 (Hamming bound).
    function automatic int unsigned get_parity_width(input int unsigned data_width);
        for (int unsigned p = 1; p < 31; p++) begin
            if ((32'd1 << p) >= data_width + p + 32'd1) begin
                return p;
            end
        end
        return 31;
    endfunction

    // Code word width excluding the overall parity bit.
    function automatic int unsigned get_cw_width(input int unsigned data_width);
        return data_width + get_parity_width(data_width);
    endfunction

    // Power-of-two Hamming positions carry check bits, all others carry data.
    function automatic logic is_pow2(input int value);
        return (value > 0) && ((value & (value - 1)) == 0);
    endfunction

endpackage

// File: rtl/ecc_syndrome.sv
// Combinational SECDED syndrome and overall-parity generator.
module ecc_syndrome
    import ecc_pkg::*;
#(
    parameter int unsigned DataWidth = 64,
    localparam int unsigned P  = get_parity_width(DataWidth),
    localparam int unsigned CW = get_cw_width(DataWidth)
) (
    input  logic [CW-1:0] code_word,
    input  logic          parity,
    output logic [P-1:0]  syndrome,
    output logic          overall
);

    // Syndrome bit i covers every Hamming position whose index has bit i set.
    always_comb begin
        syndrome = '0;
        for (int unsigned i = 0; i < P; i++) begin
            for (int unsigned j = 1; j <= CW; j++) begin
                if (((j >> i) & 32'd1) != 32'd0) begin
                    syndrome[i] = syndrome[i] ^ code_word[j-1];
                end
            end
        end
    end

    // Parity across the whole received word including the overall bit.
    assign overall = ^{parity, code_word};

endmodule

// File: rtl/ecc_decode_stream.sv
// Two-stage streaming SECDED decoder with saturating error counters and sticky syndrome capture.
module ecc_decode_stream
    import ecc_pkg::*;
#(
    parameter int unsigned DataWidth = 64,
    parameter int unsigned CntWidth  = 16,
    localparam int unsigned P  = get_parity_width(DataWidth),
    localparam int unsigned CW = get_cw_width(DataWidth)
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 in_valid_i,
    output logic                 in_ready_o,
    input  logic [CW:0]          in_data_i,
    output logic                 out_valid_o,
    input  logic                 out_ready_i,
    output logic [DataWidth-1:0] out_data_o,
    output logic                 out_single_o,
    output logic                 out_double_o,
    input  logic                 clear_i,
    output logic [CntWidth-1:0]  single_cnt_o,
    output logic [CntWidth-1:0]  double_cnt_o,
    output logic                 err_valid_o,
    output logic [P-1:0]         err_syndrome_o
);

    localparam logic [CntWidth-1:0] CntMax = {CntWidth{1'b1}};

    logic                 s1_valid;
    logic [CW-1:0]        s1_cw;
    logic [P-1:0]         s1_syn;
    logic                 s1_par;
    logic [P-1:0]         s2_syn;
    logic                 s2_ready;
    logic [P-1:0]         syn_c;
    logic                 par_c;
    ecc_status_e          status_c;
    logic                 flip_c;
    logic [CW-1:0]        cw_fix_c;
    logic [DataWidth-1:0] data_c;
    logic                 out_hs;
    logic                 single_hs;
    logic                 double_hs;
    logic                 err_hs;

    assign s2_ready   = !out_valid_o || out_ready_i;
    assign in_ready_o = !s1_valid || s2_ready;

    ecc_syndrome #(
        .DataWidth(DataWidth)
    ) u_syndrome (
        .code_word(in_data_i[CW-1:0]),
        .parity   (in_data_i[CW]),
        .syndrome (syn_c),
        .overall  (par_c)
    );

    // Classify the stage-1 word and flip the located bit for a correctable error.
    always_comb begin
        status_c = EccOk;
        flip_c   = 1'b0;
        cw_fix_c = s1_cw;
        if (s1_par) begin
            if (s1_syn == '0) begin
                status_c = EccSingle;
            end else if (32'(s1_syn) <= CW) begin
                status_c = EccSingle;
                flip_c   = 1'b1;
            end else begin
                status_c = EccDouble;
            end
        end else if (s1_syn != '0) begin
            status_c = EccDouble;
        end
        for (int unsigned k = 0; k < CW; k++) begin
            if (flip_c && (s1_syn == P'(k + 1))) begin
                cw_fix_c[k] = !cw_fix_c[k];
            end
        end
    end

    // Gather data bits from the non-power-of-two positions in ascending order.
    always_comb begin : extract_blk
        int unsigned idx;
        idx    = 0;
        data_c = '0;
        for (int k = 1; k <= int'(CW); k++) begin
            if (!is_pow2(k)) begin
                data_c[idx] = cw_fix_c[k-1];
                idx         = idx + 1;
            end
        end
    end

    // Stage 1: capture code word, syndrome and overall parity on an input handshake.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            s1_valid <= 1'b0;
            s1_cw    <= '0;
            s1_syn   <= '0;
            s1_par   <= 1'b0;
        end else if (in_ready_o) begin
            s1_valid <= in_valid_i;
            if (in_valid_i) begin
                s1_cw  <= in_data_i[CW-1:0];
                s1_syn <= syn_c;
                s1_par <= par_c;
            end
        end
    end

    // Stage 2: corrected data and flags, held while the consumer stalls.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            out_valid_o  <= 1'b0;
            out_data_o   <= '0;
            out_single_o <= 1'b0;
            out_double_o <= 1'b0;
            s2_syn       <= '0;
        end else if (s2_ready) begin
            out_valid_o <= s1_valid;
            if (s1_valid) begin
                out_data_o   <= data_c;
                out_single_o <= (status_c == EccSingle);
                out_double_o <= (status_c == EccDouble);
                s2_syn       <= s1_syn;
            end
        end
    end

    assign out_hs    = out_valid_o && out_ready_i;
    assign single_hs = out_hs && out_single_o;
    assign double_hs = out_hs && out_double_o;
    assign err_hs    = single_hs || double_hs;

    // Saturating per-flag counters, advanced when a word leaves the decoder.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            single_cnt_o <= '0;
            double_cnt_o <= '0;
        end else if (clear_i) begin
            single_cnt_o <= CntWidth'(single_hs);
            double_cnt_o <= CntWidth'(double_hs);
        end else begin
            if (single_hs && (single_cnt_o != CntMax)) begin
                single_cnt_o <= single_cnt_o + CntWidth'(1);
            end
            if (double_hs && (double_cnt_o != CntMax)) begin
                double_cnt_o <= double_cnt_o + CntWidth'(1);
            end
        end
    end

    // Sticky capture of the first erroneous word's syndrome since reset or clear.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            err_valid_o    <= 1'b0;
            err_syndrome_o <= '0;
        end else if (clear_i) begin
            err_valid_o    <= err_hs;
            err_syndrome_o <= err_hs ? s2_syn : '0;
        end else if (err_hs && !err_valid_o) begin
            err_valid_o    <= 1'b1;
            err_syndrome_o <= s2_syn;
        end
    end

endmodule

// File: tb/tb_ecc_decode_stream.sv
// Randomized scoreboard bench for ecc_decode_stream (DataWidth=8, wide and 2-bit counter instances).
module tb_ecc_decode_stream;

    typedef struct packed {
        logic [7:0] data;
        logic       single;
        logic       dbl;
        logic [3:0] syn;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [12:0] in_data;
    logic        out_valid;
    logic        out_ready;
    logic [7:0]  out_data;
    logic        out_single;
    logic        out_double;
    logic        clear;
    logic [15:0] single_cnt;
    logic [15:0] double_cnt;
    logic        err_valid;
    logic [3:0]  err_syn;

    logic        s_in_ready;
    logic        s_out_valid;
    logic [7:0]  s_out_data;
    logic        s_out_single;
    logic        s_out_double;
    logic [1:0]  s_single_cnt;
    logic [1:0]  s_double_cnt;
    logic        s_err_valid;
    logic [3:0]  s_err_syn;

    int   n_checks = 0;
    int   n_errors = 0;
    exp_t sb[$];
    exp_t cur_exp;

    int unsigned m_single;
    int unsigned m_double;
    logic        m_ev;
    logic [3:0]  m_syn;
    logic        prev_stall;
    logic [7:0]  prev_data;
    logic        prev_single;
    logic        prev_double;

    always #5 clk = !clk;

    ecc_decode_stream #(.DataWidth(8), .CntWidth(16)) dut (
        .clk_i(clk), .rst_ni(rst_n),
        .in_valid_i(in_valid), .in_ready_o(in_ready), .in_data_i(in_data),
        .out_valid_o(out_valid), .out_ready_i(out_ready), .out_data_o(out_data),
        .out_single_o(out_single), .out_double_o(out_double),
        .clear_i(clear), .single_cnt_o(single_cnt), .double_cnt_o(double_cnt),
        .err_valid_o(err_valid), .err_syndrome_o(err_syn)
    );

    ecc_decode_stream #(.DataWidth(8), .CntWidth(2)) dut_sat (
        .clk_i(clk), .rst_ni(rst_n),
        .in_valid_i(in_valid), .in_ready_o(s_in_ready), .in_data_i(in_data),
        .out_valid_o(s_out_valid), .out_ready_i(out_ready), .out_data_o(s_out_data),
        .out_single_o(s_out_single), .out_double_o(s_out_double),
        .clear_i(clear), .single_cnt_o(s_single_cnt), .double_cnt_o(s_double_cnt),
        .err_valid_o(s_err_valid), .err_syndrome_o(s_err_syn)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int unsigned sat(input int unsigned v, input int unsigned mx);
        return (v > mx) ? mx : v;
    endfunction

    // Data bits go to non-power-of-two positions; check bits make the XOR of set positions zero.
    function automatic logic [12:0] encode(input logic [7:0] d);
        logic [11:0] cw;
        logic [31:0] x;
        int          idx;
        cw  = '0;
        x   = '0;
        idx = 0;
        for (int k = 1; k <= 12; k++) begin
            if ((k & (k - 1)) != 0) begin
                cw[k-1] = d[idx];
                if (d[idx]) x = x ^ 32'(k);
                idx++;
            end
        end
        for (int i = 0; i < 4; i++) begin
            if (x[i]) cw[(1 << i) - 1] = 1'b1;
        end
        return {^cw, cw};
    endfunction

    function automatic logic [7:0] extract(input logic [11:0] cw);
        logic [7:0] d;
        int         idx;
        d   = '0;
        idx = 0;
        for (int k = 1; k <= 12; k++) begin
            if ((k & (k - 1)) != 0) begin
                d[idx] = cw[k-1];
                idx++;
            end
        end
        return d;
    endfunction

    // Expectations follow from how many bits were flipped and where, not from the syndrome logic.
    function automatic void build(input logic [7:0] d, input logic [12:0] mask,
                                  output logic [12:0] w, output exp_t e);
        int nflip;
        w       = encode(d) ^ mask;
        nflip   = $countones(mask);
        e.data  = (nflip >= 2) ? extract(w[11:0]) : d;
        e.single = (nflip == 1);
        e.dbl    = (nflip >= 2);
        e.syn    = '0;
        for (int b = 0; b < 12; b++) begin
            if (mask[b]) e.syn = e.syn ^ 4'(b + 1);
        end
    endfunction

    function automatic logic [12:0] rand_mask();
        int          nflip;
        int unsigned a;
        int unsigned b;
        logic [12:0] m;
        m     = '0;
        nflip = ($urandom_range(3, 0) == 0) ? 0 : int'($urandom_range(2, 1));
        a     = $urandom_range(12, 0);
        b     = (a + $urandom_range(12, 1)) % 13;
        if (nflip >= 1) m[a] = 1'b1;
        if (nflip == 2) m[b] = 1'b1;
        return m;
    endfunction

    // Scoreboard monitor; handshakes seen here take effect on the following rising edge.
    always @(negedge clk) begin
        exp_t e;
        logic out_hs;
        logic in_hs;
        if (!rst_n) begin
            sb.delete();
            m_single   = 0;
            m_double   = 0;
            m_ev       = 1'b0;
            m_syn      = '0;
            prev_stall = 1'b0;
        end else begin
            check("single_cnt", 32'(single_cnt), sat(m_single, 65535));
            check("double_cnt", 32'(double_cnt), sat(m_double, 65535));
            check("sat_single_cnt", 32'(s_single_cnt), sat(m_single, 3));
            check("sat_double_cnt", 32'(s_double_cnt), sat(m_double, 3));
            check("err_valid", 32'(err_valid), 32'(m_ev));
            check("err_syn", 32'(err_syn), 32'(m_syn));
            check("sat_err_syn", 32'(s_err_syn), 32'(m_syn));
            check("sat_err_valid", 32'(s_err_valid), 32'(m_ev));
            if (prev_stall) begin
                check("stall_valid", 32'(out_valid), 32'(1));
                check("stall_data", 32'(out_data), 32'(prev_data));
                check("stall_flags", 32'({out_single, out_double}), 32'({prev_single, prev_double}));
            end
            out_hs = out_valid && out_ready;
            in_hs  = in_valid && in_ready;
            e      = '0;
            if (out_hs) begin
                if (sb.size() == 0) begin
                    check("unexpected_out", 32'(1), 32'(0));
                end else begin
                    e = sb.pop_front();
                    check("out_data", 32'(out_data), 32'(e.data));
                    check("out_single", 32'(out_single), 32'(e.single));
                    check("out_double", 32'(out_double), 32'(e.dbl));
                    check("sat_out", 32'({s_out_valid, s_out_data, s_out_single, s_out_double}),
                          32'({1'b1, e.data, e.single, e.dbl}));
                end
            end
            if (clear) begin
                m_single = (out_hs && e.single) ? 1 : 0;
                m_double = (out_hs && e.dbl) ? 1 : 0;
                m_ev     = out_hs && (e.single || e.dbl);
                m_syn    = m_ev ? e.syn : 4'h0;
            end else if (out_hs) begin
                if (e.single) m_single++;
                if (e.dbl) m_double++;
                if ((e.single || e.dbl) && !m_ev) begin
                    m_ev  = 1'b1;
                    m_syn = e.syn;
                end
            end
            if (in_hs) begin
                check("sat_in_ready", 32'(s_in_ready), 32'(1));
                sb.push_back(cur_exp);
            end
            prev_stall  = out_valid && !out_ready;
            prev_data   = out_data;
            prev_single = out_single;
            prev_double = out_double;
        end
    end

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_word(input logic [12:0] w, input exp_t e);
        logic took;
        int   n;
        in_valid = 1'b1;
        in_data  = w;
        cur_exp  = e;
        n        = 0;
        do begin
            @(negedge clk);
            took = in_ready;
            @(posedge clk);
            #1;
            n++;
        end while (!took && n < 200);
        if (!took) check("send_timeout", 32'(0), 32'(1));
        in_valid = 1'b0;
    endtask

    initial begin
        logic [12:0] w;
        exp_t        e;
        logic        took;
        int          sent;
        int          n;

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b1;
        clear     = 1'b0;
        cur_exp   = '0;
        idle(3);
        check("rst_out_valid", 32'(out_valid), 32'(0));
        check("rst_out", 32'({out_data, out_single, out_double}), 32'(0));
        check("rst_cnt", 32'({single_cnt, double_cnt}), 32'(0));
        check("rst_sticky", 32'({err_valid, err_syn}), 32'(0));
        check("rst_in_ready", 32'(in_ready), 32'(1));
        rst_n = 1'b1;
        idle(2);

        // Clean word and pipeline latency.
        build(8'hA5, 13'h0, w, e);
        send_word(w, e);
        check("a5_lat1", 32'(out_valid), 32'(0));
        idle(1);
        check("a5_lat2", 32'(out_valid), 32'(1));
        check("a5_data", 32'(out_data), 32'(8'hA5));
        check("a5_flags", 32'({out_single, out_double}), 32'(0));
        idle(2);
        check("a5_cnt", 32'({single_cnt, double_cnt}), 32'(0));

        // Single error at code bit 4 (position 5).
        build(8'h00, 13'h0010, w, e);
        send_word(w, e);
        idle(3);
        check("s5_cnt", 32'(single_cnt), 32'(1));
        check("s5_sticky", 32'({err_valid, err_syn}), 32'({1'b1, 4'd5}));

        // Error in the overall parity bit; sticky keeps the first syndrome.
        build(8'h00, 13'h1000, w, e);
        send_word(w, e);
        idle(3);
        check("par_cnt", 32'(single_cnt), 32'(2));
        check("par_sticky", 32'(err_syn), 32'(5));

        // Double error at code bits 0 and 1.
        build(8'h00, 13'h0003, w, e);
        send_word(w, e);
        idle(3);
        check("dbl_cnt", 32'(double_cnt), 32'(1));

        // Three more singles: narrow counter saturates at 3, wide one keeps counting.
        for (int i = 0; i < 3; i++) begin
            build(8'($urandom), 13'(1 << $urandom_range(11, 0)), w, e);
            send_word(w, e);
        end
        idle(3);
        check("sat_single3", 32'(s_single_cnt), 32'(3));
        check("wide_single5", 32'(single_cnt), 32'(5));

        // Clear coinciding with an error handshake reloads to that word.
        build(8'h3C, 13'h0004, w, e);
        send_word(w, e);
        @(posedge clk);
        #1;
        clear = 1'b1;
        idle(1);
        clear = 1'b0;
        check("clr_single", 32'({single_cnt, s_single_cnt}), 32'({16'd1, 2'd1}));
        check("clr_double", 32'(double_cnt), 32'(0));
        check("clr_sticky", 32'({err_valid, err_syn}), 32'({1'b1, 4'd3}));

        // Random back-to-back traffic with a 50% consumer stall and occasional clears.
        sent = 0;
        n    = 0;
        build(8'($urandom), rand_mask(), w, e);
        in_valid = 1'b1;
        in_data  = w;
        cur_exp  = e;
        while (sent < 100 && n < 5000) begin
            @(negedge clk);
            took = in_valid && in_ready;
            @(posedge clk);
            #1;
            n++;
            if (took) sent++;
            out_ready = ($urandom_range(1, 0) == 1);
            clear     = ($urandom_range(31, 0) == 0);
            if (took || !in_valid) begin
                build(8'($urandom), rand_mask(), w, e);
                in_data  = w;
                cur_exp  = e;
                in_valid = (sent < 100) && ($urandom_range(3, 0) != 0);
            end
        end
        check("rand_sent", 32'(sent), 32'(100));
        in_valid  = 1'b0;
        clear     = 1'b0;
        out_ready = 1'b1;
        n         = 0;
        while (sb.size() != 0 && n < 100) begin
            idle(1);
            n++;
        end
        check("drain", 32'(sb.size()), 32'(0));
        idle(2);
        check("drain_idle", 32'(out_valid), 32'(0));

        // Reset with words in flight: they must vanish.
        out_ready = 1'b0;
        build(8'h11, 13'h0001, w, e);
        send_word(w, e);
        build(8'h22, 13'h0000, w, e);
        send_word(w, e);
        rst_n = 1'b0;
        #1;
        check("mid_rst_valid", 32'({out_valid, s_out_valid}), 32'(0));
        check("mid_rst_out", 32'({out_data, out_single, out_double}), 32'(0));
        check("mid_rst_cnt", 32'({single_cnt, double_cnt, s_single_cnt, s_double_cnt}), 32'(0));
        check("mid_rst_sticky", 32'({err_valid, err_syn}), 32'(0));
        idle(2);
        rst_n     = 1'b1;
        out_ready = 1'b1;
        idle(5);
        check("post_rst_valid", 32'(out_valid), 32'(0));
        check("post_rst_sb", 32'(sb.size()), 32'(0));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
